// File: rtl/aes_ct_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module   : aes_ct_uart_streamer
// Purpose  : Captures AES ciphertext on core completion and streams it as an
//            8N1 UART frame (sync byte + 16 ciphertext bytes, MSB byte first).
// Revision : 1.0 - initial release
// ============================================================================
module aes_ct_uart_streamer #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         busy_i,
    input  logic [127:0] data_i,
    output logic         tx_o,
    output logic         tx_busy_o,
    output logic         overrun_o,
    output logic [7:0]   frame_count_o
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_START     = 2'd1;
    localparam logic [1:0]  c_DATA      = 2'd2;
    localparam logic [1:0]  c_STOP      = 2'd3;
    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  c_LAST_BYTE = 5'd16;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic         r_busy_d;
    logic [15:0]  r_baud_cnt;
    logic [2:0]   r_bit_idx;
    logic [4:0]   r_byte_idx;
    logic [127:0] r_shift;
    logic         r_tx;
    logic         r_tx_busy;
    logic         r_overrun;
    logic         r_frame_done;
    logic [7:0]   r_frame_count;

    logic         w_complete;
    logic         w_accept;
    logic         w_baud_done;
    logic [7:0]   w_cur_byte;
    logic         w_tx_next;
    logic         w_frame_done;

    // Acceptance looks at the registered busy flag, so the cycle in which the
    // FSM has already returned to IDLE still counts as busy.
    assign w_complete  = r_busy_d & ~busy_i;
    assign w_accept    = w_complete & ~r_tx_busy & (r_state == c_IDLE);
    assign w_baud_done = (r_baud_cnt == c_BAUD_LAST);
    assign w_cur_byte  = (r_byte_idx == 5'd0) ? SYNC_BYTE : r_shift[127:120];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)    w_state_next = c_START;
            c_START: if (w_baud_done) w_state_next = c_DATA;
            c_DATA:  if (w_baud_done && (r_bit_idx == 3'd7)) w_state_next = c_STOP;
            c_STOP:  if (w_baud_done) w_state_next = (r_byte_idx < c_LAST_BYTE) ? c_START : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next    = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            c_START: w_tx_next = 1'b0;
            c_DATA:  w_tx_next = w_cur_byte[r_bit_idx];
            c_STOP:  w_frame_done = w_baud_done && (r_byte_idx == c_LAST_BYTE);
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_d      <= 1'b0;
            r_baud_cnt    <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_byte_idx    <= 5'd0;
            r_shift       <= 128'd0;
            r_tx          <= 1'b1;
            r_tx_busy     <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_busy_d     <= busy_i;
            r_tx         <= w_tx_next;
            r_tx_busy    <= (r_state != c_IDLE);
            r_overrun    <= w_complete & ~w_accept;
            r_frame_done <= w_frame_done;
            if (r_frame_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end

            if ((r_state == c_IDLE) || w_baud_done || (r_state != w_state_next)) begin
                r_baud_cnt <= 16'd0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            if ((r_state == c_START) && w_baud_done) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == c_DATA) && w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_accept) begin
                r_byte_idx <= 5'd0;
                r_shift    <= data_i;
            end else if ((r_state == c_STOP) && w_baud_done && (r_byte_idx < c_LAST_BYTE)) begin
                r_byte_idx <= r_byte_idx + 5'd1;
                if (r_byte_idx != 5'd0) begin
                    r_shift <= {r_shift[119:0], 8'd0};
                end
            end
        end
    end

    assign tx_o          = r_tx;
    assign tx_busy_o     = r_tx_busy;
    assign overrun_o     = r_overrun;
    assign frame_count_o = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_ct_uart_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aes_ct_uart_streamer
// Purpose  : Self-checking bench for aes_ct_uart_streamer against a bit-slot
//            model of the 8N1 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ct_uart_streamer;

    localparam int CPB   = 4;
    localparam int L     = 170 * CPB;
    localparam int WCPB  = 2;
    localparam int WL    = 170 * WCPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         busy;
    logic [127:0] data;
    logic         tx, txb, ovr;
    logic [7:0]   fc;

    logic         wrst;
    logic         wbusy;
    logic [127:0] wdata;
    logic         wtx, wtxb, wovr;
    logic [7:0]   wfc;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_fc   = 0;

    always #5 clk = ~clk;

    aes_ct_uart_streamer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .busy_i(busy), .data_i(data),
        .tx_o(tx), .tx_busy_o(txb), .overrun_o(ovr), .frame_count_o(fc)
    );

    aes_ct_uart_streamer #(.CLKS_PER_BIT(WCPB), .SYNC_BYTE(8'hA5)) dut_w (
        .clk(clk), .rst(wrst), .busy_i(wbusy), .data_i(wdata),
        .tx_o(wtx), .tx_busy_o(wtxb), .overrun_o(wovr), .frame_count_o(wfc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    endtask

    // Model: frame byte b (0 = sync, 1..16 = ciphertext MSB byte first)
    function automatic logic [7:0] frame_byte(input logic [127:0] d, input int b);
        logic [127:0] t;
        if (b == 0) return 8'hA5;
        t = d >> (8 * (16 - b));
        return t[7:0];
    endfunction

    // Model: expected line level in bit slot k (10 slots per byte: start, 8 LSB-first, stop)
    function automatic logic exp_bit(input logic [127:0] d, input int k);
        int pos;
        logic [7:0] byt;
        pos = k % 10;
        byt = frame_byte(d, k / 10);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_cmp(input logic [127:0] d);
        @(negedge clk); busy = 1'b1; data = d;
        @(negedge clk); busy = 1'b0;
    endtask

    // Follows one frame whose completion is sampled on the next rising edge.
    // mode 1: extra completion mid-frame; mode 2: completion in last STOP cycle,
    // then a completion one cycle after tx_busy falls carrying nd.
    task automatic run_frame(input logic [127:0] d, input int mode, input int exp_ovr,
                             input logic [127:0] nd);
        logic [L-1:0] wave;
        int busy_cnt, ovr_cnt, wmis;
        logic [7:0] got;
        busy_cnt = 0; ovr_cnt = 0; wmis = 0;
        @(posedge clk);
        @(negedge clk);
        busy_cnt += int'(txb); ovr_cnt += int'(ovr);
        data = rnd128();
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            wave[c] = tx;
            busy_cnt += int'(txb);
            ovr_cnt  += int'(ovr);
            if (mode == 1 && c == 200) busy = 1'b1;
            if (mode == 1 && c == 201) begin busy = 1'b0; data = rnd128(); end
            if (mode == 2 && c == L-3) busy = 1'b1;
            if (mode == 2 && c == L-2) begin busy = 1'b0; data = rnd128(); end
            if (mode == 2 && c == L-1) busy = 1'b1;
        end
        @(negedge clk);
        busy_cnt += int'(txb); ovr_cnt += int'(ovr);
        exp_fc = (exp_fc + 1) % 256;
        chk("frame_count", 32'(fc), 32'(exp_fc));
        if (mode == 2) begin
            busy = 1'b0;
            data = nd;
        end
        for (int c = 0; c < L; c++) begin
            if (wave[c] !== exp_bit(d, c / CPB)) wmis++;
        end
        chk("wave_mismatches", 32'(wmis), 32'd0);
        chk("busy_cycles", 32'(busy_cnt), 32'(L));
        chk("overrun_pulses", 32'(ovr_cnt), 32'(exp_ovr));
        for (int b = 0; b < 17; b++) begin
            for (int j = 0; j < 8; j++) got[j] = wave[(b*10 + 1 + j)*CPB + CPB/2];
            chk($sformatf("byte%0d", b), 32'(got), 32'(frame_byte(d, b)));
        end
    endtask

    initial begin
        rst = 1'b1; busy = 1'b0; data = '0;
        wrst = 1'b1; wbusy = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; wrst = 1'b0;
        fork
            begin : main_seq
                int lo, bz, ov;
                logic [127:0] nd;
                @(negedge clk);
                chk("rst_tx", 32'(tx), 32'd1);
                chk("rst_busy", 32'(txb), 32'd0);
                chk("rst_ovr", 32'(ovr), 32'd0);
                chk("rst_fc", 32'(fc), 32'd0);
                lo = 0; bz = 0; ov = 0;
                repeat (100) begin
                    @(negedge clk);
                    lo += int'(!tx); bz += int'(txb); ov += int'(ovr);
                end
                chk("idle_tx_low", 32'(lo), 32'd0);
                chk("idle_busy", 32'(bz), 32'd0);
                chk("idle_ovr", 32'(ov), 32'd0);
                chk("idle_fc", 32'(fc), 32'd0);

                start_cmp(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
                run_frame(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, '0);

                repeat (5) @(negedge clk);
                nd = rnd128();
                start_cmp(nd);
                run_frame(nd, 1, 1, '0);
                bz = 0;
                repeat (50) begin @(negedge clk); bz += int'(txb); end
                chk("no_second_frame", 32'(bz), 32'd0);

                nd = rnd128();
                start_cmp(nd);
                begin
                    logic [127:0] nd2;
                    nd2 = rnd128();
                    run_frame(nd, 2, 1, nd2);
                    run_frame(nd2, 0, 0, '0);
                end

                repeat (5) @(negedge clk);
                start_cmp(rnd128());
                @(posedge clk);
                repeat (1 + 80*CPB + 3*CPB + 1) @(negedge clk);
                chk("midframe_busy", 32'(txb), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_tx", 32'(tx), 32'd1);
                chk("abort_busy", 32'(txb), 32'd0);
                chk("abort_fc", 32'(fc), 32'd0);
                chk("abort_ovr", 32'(ovr), 32'd0);
                rst = 1'b0;
                exp_fc = 0;
                nd = rnd128();
                start_cmp(nd);
                run_frame(nd, 0, 0, '0);
            end
            begin : wrap_seq
                int stuck;
                stuck = 0;
                for (int i = 0; i < 256; i++) begin
                    if (i == 255) chk("wrap_before", 32'(wfc), 32'd255);
                    stuck += int'(wtxb);
                    @(negedge clk); wbusy = 1'b1; wdata = rnd128();
                    @(negedge clk); wbusy = 1'b0;
                    repeat (WL + 2) @(negedge clk);
                end
                chk("wrap_stuck_busy", 32'(stuck), 32'd0);
                chk("wrap_after", 32'(wfc), 32'd0);
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
